history_replay_sampler: RTL and testbench
=========================================

Name: history_replay_sampler

Overview:
- Reader side of the Dyna-Q transition history. Captures each remembered transition (location, action, next location, reward) into a small model memory.
- On request, runs a planning session of PLAN_STEPS replays. Each replay is a pseudo-randomly chosen stored transition, issued to the Q-update datapath over a valid/ready handshake.
- Sits between the history table outputs and the Q-value update unit.

Parameters:
- LOCATION_LENGTH, 8, location width
- REWARD_LENGTH, 11, reward width
- DEPTH, 16, model memory entries (power of two)
- ADDR_LENGTH, 4, log2(DEPTH)
- PLAN_STEPS, 5, replays per planning session (>=1)
- LFSR_SEED, 16'hACE1, LFSR reset value (non-zero)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-low reset
- capture  in  1  1-cycle strobe: write current remember_* inputs into memory
- remember_location  in  LOCATION_LENGTH  transition source location
- remember_action  in  2  transition action
- remember_n_location  in  LOCATION_LENGTH  transition next location
- remember_reward  in  REWARD_LENGTH  transition reward
- plan_start  in  1  start a planning session
- replay_valid  out  1  replay outputs valid
- replay_ready  in  1  consumer accepts replay
- replay_location  out  LOCATION_LENGTH  replayed location
- replay_action  out  2  replayed action
- replay_n_location  out  LOCATION_LENGTH  replayed next location
- replay_reward  out  REWARD_LENGTH  replayed reward
- busy  out  1  session in progress
- done  out  1  1-cycle pulse at session end
- entry_count  out  ADDR_LENGTH+1  valid entries stored

Behaviour:
- Reset (reset==0 at a clk edge): all outputs 0; wr_ptr=0; entry_count=0; step counter=0; FSM=IDLE; LFSR=LFSR_SEED. Memory contents are don't-care. Reset mid-session aborts the session with no done pulse.
- Capture:
  - capture=1 writes {location, action, n_location, reward} to mem[wr_ptr]. wr_ptr increments and wraps DEPTH-1 -> 0.
  - entry_count increments and saturates at DEPTH; after saturation the oldest entry is overwritten.
  - Capture is accepted in every FSM state. It never disturbs the registered replay_* outputs, even when it overwrites the entry being issued.
- LFSR: 16-bit Fibonacci, right shift.
  - fb = l[0]^l[2]^l[3]^l[5]; next = {fb, l[15:1]}.
  - Advances only on cycles spent in PICK.
  - Candidate idx = low ADDR_LENGTH bits of the advanced value.
- FSM states: IDLE, PICK, ISSUE, DONE.
  - IDLE: busy=0. On plan_start=1, step=0 and busy=1. Goes to PICK if entry_count>0, else DONE (zero replays). entry_count is sampled in the same cycle, so a simultaneous capture does not count.
  - PICK:
    - Advance the LFSR.
    - If idx<entry_count: register mem[idx] onto replay_*, set replay_valid=1 next cycle, go to ISSUE.
    - Otherwise stay in PICK (rejection sampling; terminates because the LFSR is maximal-length).
  - ISSUE: replay_valid=1; replay_* held stable until replay_valid&replay_ready.
    - On handshake: replay_valid=0 next cycle, step++.
    - If step==PLAN_STEPS after the increment, go to DONE; else go to PICK.
    - No combinational path from replay_ready to replay_valid.
  - DONE: done=1 for exactly one cycle, busy=0 from the next cycle, go to IDLE.
- plan_start while busy is ignored; it is not queued.
- Minimum replay latency is 1 cycle from PICK entry to replay_valid.

Optional Feature:
- Macro REPLAY_LATEST_FIRST_EN.
- Defined: the first replay of each session uses mem[wr_ptr-1], the most recent entry (mod DEPTH). Its PICK takes one cycle and does not advance the LFSR. Later replays are random as described above.
- Undefined: all replays are LFSR-selected.

Test Plan (feature undefined unless stated):
1. Reset, then plan_start with no captures -> no replay_valid; done pulses 2 cycles after plan_start; entry_count=0.
2. Capture one transition (loc 8'h12, act 2'b01, nloc 8'h13, rew 11'h005), then plan_start with replay_ready tied 1 -> 5 replays, all {12,1,13,005}. The first PICK gives LFSR 0x5670 / idx 0 in one cycle; done follows the 5th handshake.
3. Fill 20 captures with loc=i -> entry_count saturates at 16; entries 0-3 are overwritten by loc 16-19. Every replayed loc is in 4..19.
4. Backpressure: hold replay_ready=0 for 10 cycles during ISSUE and capture 3 entries -> replay_valid stays 1, replay_* unchanged, step count not advanced.
5. Assert reset=0 during ISSUE of step 2 -> next cycle all outputs 0, no done pulse. A new session replays from LFSR_SEED (idx sequence repeats test 2's).
6. REPLAY_LATEST_FIRST_EN defined, captures loc 1,2,3 -> first replay loc=3; subsequent replays are random from {1,2,3}.

Source files
------------

// File: rtl/history_replay_sampler.sv
// rtl/history_replay_sampler.sv - Dyna-Q transition model memory with LFSR-driven planning replays (optional: REPLAY_LATEST_FIRST_EN)
module history_replay_sampler #(
    parameter int          LOCATION_LENGTH = 8,
    parameter int          REWARD_LENGTH   = 11,
    parameter int          DEPTH           = 16,
    parameter int          ADDR_LENGTH     = 4,
    parameter int          PLAN_STEPS      = 5,
    parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       capture,
    input  logic [LOCATION_LENGTH-1:0] remember_location,
    input  logic [1:0]                 remember_action,
    input  logic [LOCATION_LENGTH-1:0] remember_n_location,
    input  logic [REWARD_LENGTH-1:0]   remember_reward,
    input  logic                       plan_start,
    output logic                       replay_valid,
    input  logic                       replay_ready,
    output logic [LOCATION_LENGTH-1:0] replay_location,
    output logic [1:0]                 replay_action,
    output logic [LOCATION_LENGTH-1:0] replay_n_location,
    output logic [REWARD_LENGTH-1:0]   replay_reward,
    output logic                       busy,
    output logic                       done,
    output logic [ADDR_LENGTH:0]       entry_count
);

    localparam int ENTRY_LENGTH = 2 * LOCATION_LENGTH + 2 + REWARD_LENGTH;
    localparam int STEP_LENGTH  = (PLAN_STEPS > 1) ? $clog2(PLAN_STEPS) : 1;
    localparam logic [STEP_LENGTH-1:0] STEP_LAST  = STEP_LENGTH'(PLAN_STEPS - 1);
    localparam logic [ADDR_LENGTH:0]   COUNT_FULL = (ADDR_LENGTH + 1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PICK,
        S_ISSUE,
        S_DONE
    } state_t;

    // Model memory and write side
    logic [ENTRY_LENGTH-1:0]    r_mem [DEPTH];
    logic [ADDR_LENGTH-1:0]     r_wr_ptr;
    logic [ADDR_LENGTH:0]       r_entry_count;

    // Sampler state
    state_t                     r_state;
    logic [15:0]                r_lfsr;
    logic [STEP_LENGTH-1:0]     r_step;
    logic                       r_replay_valid;
    logic [LOCATION_LENGTH-1:0] r_replay_location;
    logic [1:0]                 r_replay_action;
    logic [LOCATION_LENGTH-1:0] r_replay_n_location;
    logic [REWARD_LENGTH-1:0]   r_replay_reward;
    logic                       r_busy;
    logic                       r_done;

    // Combinational helpers
    logic [ENTRY_LENGTH-1:0]    w_wr_data;
    logic [ENTRY_LENGTH-1:0]    w_rd_entry;
    logic                       w_lfsr_fb;
    logic [15:0]                w_lfsr_next;
    logic [ADDR_LENGTH-1:0]     w_cand_idx;
    logic [ADDR_LENGTH-1:0]     w_rd_idx;
    logic                       w_use_latest;
    logic                       w_pick_hit;

    assign w_wr_data = {remember_location, remember_action, remember_n_location, remember_reward};

    // The candidate index is taken from the value the LFSR is advancing to this cycle
    assign w_lfsr_fb   = r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5];
    assign w_lfsr_next = {w_lfsr_fb, r_lfsr[15:1]};
    assign w_cand_idx  = w_lfsr_next[ADDR_LENGTH-1:0];

`ifdef REPLAY_LATEST_FIRST_EN
    logic r_first;

    // First PICK of a session replays the newest entry without touching the LFSR
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_first <= 1'b0;
        end else if (r_state == S_IDLE && plan_start) begin
            r_first <= 1'b1;
        end else if (r_state == S_PICK) begin
            r_first <= 1'b0;
        end
    end

    assign w_use_latest = r_first;
`else
    assign w_use_latest = 1'b0;
`endif

    // Latest entry sits just behind the write pointer; a non-empty memory always accepts it
    assign w_rd_idx   = w_use_latest ? (r_wr_ptr - ADDR_LENGTH'(1)) : w_cand_idx;
    assign w_pick_hit = w_use_latest || ({1'b0, w_cand_idx} < r_entry_count);
    assign w_rd_entry = r_mem[w_rd_idx];

    // Memory write port; contents are intentionally left unreset
    always_ff @(posedge clk) begin
        if (reset && capture) begin
            r_mem[r_wr_ptr] <= w_wr_data;
        end
    end

    // Write pointer wraps naturally; count saturates so the oldest slot is overwritten once full
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wr_ptr      <= '0;
            r_entry_count <= '0;
        end else if (capture) begin
            r_wr_ptr <= r_wr_ptr + ADDR_LENGTH'(1);
            if (r_entry_count != COUNT_FULL) begin
                r_entry_count <= r_entry_count + (ADDR_LENGTH + 1)'(1);
            end
        end
    end

    // Planning FSM: rejection-sample an index, present it, wait for the consumer, repeat
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state             <= S_IDLE;
            r_lfsr              <= LFSR_SEED;
            r_step              <= '0;
            r_replay_valid      <= 1'b0;
            r_replay_location   <= '0;
            r_replay_action     <= '0;
            r_replay_n_location <= '0;
            r_replay_reward     <= '0;
            r_busy              <= 1'b0;
            r_done              <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (plan_start) begin
                        r_step  <= '0;
                        r_busy  <= 1'b1;
                        // Count sampled before any same-cycle capture lands
                        r_state <= (r_entry_count != '0) ? S_PICK : S_DONE;
                    end
                end
                S_PICK: begin
                    if (!w_use_latest) begin
                        r_lfsr <= w_lfsr_next;
                    end
                    if (w_pick_hit) begin
                        {r_replay_location, r_replay_action,
                         r_replay_n_location, r_replay_reward} <= w_rd_entry;
                        r_replay_valid <= 1'b1;
                        r_state        <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (replay_ready) begin
                        r_replay_valid <= 1'b0;
                        r_step         <= r_step + STEP_LENGTH'(1);
                        r_state        <= (r_step == STEP_LAST) ? S_DONE : S_PICK;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign replay_valid      = r_replay_valid;
    assign replay_location   = r_replay_location;
    assign replay_action     = r_replay_action;
    assign replay_n_location = r_replay_n_location;
    assign replay_reward     = r_replay_reward;
    assign busy              = r_busy;
    assign done              = r_done;
    assign entry_count       = r_entry_count;

endmodule

// File: tb/tb_history_replay_sampler.sv
// tb/tb_history_replay_sampler.sv - directed scoreboard bench for history_replay_sampler
module tb_history_replay_sampler;

    localparam int PLAN_STEPS = 5;
    localparam logic [15:0] SEED = 16'hACE1;
`ifdef REPLAY_LATEST_FIRST_EN
    localparam bit LATEST_EN = 1'b1;
`else
    localparam bit LATEST_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        capture = 1'b0;
    logic [7:0]  remember_location = '0;
    logic [1:0]  remember_action = '0;
    logic [7:0]  remember_n_location = '0;
    logic [10:0] remember_reward = '0;
    logic        plan_start = 1'b0;
    logic        replay_valid;
    logic        replay_ready = 1'b0;
    logic [7:0]  replay_location;
    logic [1:0]  replay_action;
    logic [7:0]  replay_n_location;
    logic [10:0] replay_reward;
    logic        busy;
    logic        done;
    logic [4:0]  entry_count;

    history_replay_sampler dut (
        .clk                 (clk),
        .reset               (reset),
        .capture             (capture),
        .remember_location   (remember_location),
        .remember_action     (remember_action),
        .remember_n_location (remember_n_location),
        .remember_reward     (remember_reward),
        .plan_start          (plan_start),
        .replay_valid        (replay_valid),
        .replay_ready        (replay_ready),
        .replay_location     (replay_location),
        .replay_action       (replay_action),
        .replay_n_location   (replay_n_location),
        .replay_reward       (replay_reward),
        .busy                (busy),
        .done                (done),
        .entry_count         (entry_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]  loc;
        logic [1:0]  act;
        logic [7:0]  nloc;
        logic [10:0] rew;
        logic [31:0] adv;
    } exp_t;

    exp_t        q[$];
    logic [7:0]  m_loc  [16];
    logic [1:0]  m_act  [16];
    logic [7:0]  m_nloc [16];
    logic [10:0] m_rew  [16];
    logic [3:0]  m_wp;
    int          m_cnt;
    logic [15:0] m_lfsr;
    bit          m_first;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_wp   = '0;
        m_cnt  = 0;
        m_lfsr = SEED;
        m_first = 1'b0;
        q.delete();
    endtask

    task automatic cap(input logic [7:0] loc, input logic [1:0] act,
                       input logic [7:0] nloc, input logic [10:0] rew);
        remember_location   = loc;
        remember_action     = act;
        remember_n_location = nloc;
        remember_reward     = rew;
        capture = 1'b1;
        tick();
        capture = 1'b0;
        m_loc[m_wp]  = loc;
        m_act[m_wp]  = act;
        m_nloc[m_wp] = nloc;
        m_rew[m_wp]  = rew;
        m_wp = m_wp + 4'd1;
        if (m_cnt < 16) m_cnt++;
    endtask

    // Predict the next replay and how many PICK cycles it costs
    task automatic predict_next();
        exp_t       e;
        logic [3:0] idx;
        int         adv;
        bit         latest;
        latest  = m_first & LATEST_EN;
        m_first = 1'b0;
        adv = 0;
        if (latest) begin
            idx = m_wp - 4'd1;
            adv = 1;
        end else begin
            do begin
                m_lfsr = {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
                adv++;
            end while (int'(m_lfsr[3:0]) >= m_cnt && adv < 1000);
            idx = m_lfsr[3:0];
        end
        e.loc  = m_loc[idx];
        e.act  = m_act[idx];
        e.nloc = m_nloc[idx];
        e.rew  = m_rew[idx];
        e.adv  = adv;
        q.push_back(e);
    endtask

    task automatic wait_and_compare(output exp_t e);
        int n;
        n = 0;
        while (!replay_valid && n < 200) begin
            tick();
            n++;
        end
        e = q.pop_front();
        check("pick_cycles", n, e.adv);
        check("rep_loc", replay_location, e.loc);
        check("rep_act", replay_action, e.act);
        check("rep_nloc", replay_n_location, e.nloc);
        check("rep_rew", replay_reward, e.rew);
    endtask

    task automatic run_session(input int bp_cycles, input bit poke_start, input bit check_range);
        exp_t e;
        plan_start = 1'b1;
        tick();
        plan_start = 1'b0;
        m_first = 1'b1;
        if (m_cnt == 0) begin
            check("empty_valid", replay_valid, 0);
            check("empty_busy", busy, 1);
            check("empty_done_early", done, 0);
            tick();
            check("empty_done", done, 1);
            check("empty_busy_off", busy, 0);
            check("empty_valid2", replay_valid, 0);
            tick();
            check("empty_done_off", done, 0);
            return;
        end
        for (int s = 0; s < PLAN_STEPS; s++) begin
            predict_next();
            wait_and_compare(e);
            if (check_range)
                check("loc_range", (replay_location >= 8'd4 && replay_location <= 8'd19), 1);
            if (s == 0 && bp_cycles > 0) begin
                for (int k = 0; k < bp_cycles; k++) begin
                    if (k < 3) cap(8'hA0 + 8'(k), 2'(k), 8'hB0 + 8'(k), 11'h400 + 11'(k));
                    else tick();
                    check("bp_valid", replay_valid, 1);
                    check("bp_loc", replay_location, e.loc);
                    check("bp_nloc", replay_n_location, e.nloc);
                    check("bp_rew", replay_reward, e.rew);
                    check("bp_busy", busy, 1);
                end
            end
            if (poke_start && s == 1) plan_start = 1'b1;
            replay_ready = 1'b1;
            tick();
            replay_ready = 1'b0;
            plan_start = 1'b0;
            check("post_hs_valid", replay_valid, 0);
        end
        check("done_not_yet", done, 0);
        check("busy_in_done", busy, 1);
        tick();
        check("done_pulse", done, 1);
        check("busy_off", busy, 0);
        tick();
        check("done_off", done, 0);
        if (poke_start) begin
            for (int k = 0; k < 3; k++) begin
                tick();
                check("ignored_start_busy", busy, 0);
                check("ignored_start_valid", replay_valid, 0);
            end
        end
    endtask

    initial begin
        exp_t e;
        model_reset();

        // 1: reset state and empty session
        tick();
        tick();
        check("rst_valid", replay_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_count", entry_count, 0);
        check("rst_loc", replay_location, 0);
        check("rst_rew", replay_reward, 0);
        reset = 1'b1;
        tick();
        run_session(0, 1'b0, 1'b0);
        check("t1_count", entry_count, 0);

        // 2: single entry replayed five times
        cap(8'h12, 2'b01, 8'h13, 11'h005);
        check("t2_count", entry_count, 1);
        run_session(0, 1'b0, 1'b0);

        // 3: overfill to saturation, plan_start while busy is ignored
        model_reset();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cap(8'(i), 2'(i), 8'(i + 1), 11'(i * 3));
            if (i == 15) check("t3_count16", entry_count, 16);
        end
        check("t3_count_sat", entry_count, 16);
        run_session(0, 1'b1, 1'b1);

        // 4: backpressure with captures while a replay is held
        run_session(10, 1'b0, 1'b0);
        check("t4_count", entry_count, 16);

        // 5: reset during ISSUE of step 2, then reseeded session
        plan_start = 1'b1;
        tick();
        plan_start = 1'b0;
        m_first = 1'b1;
        for (int s = 0; s < 2; s++) begin
            predict_next();
            wait_and_compare(e);
            replay_ready = 1'b1;
            tick();
            replay_ready = 1'b0;
        end
        predict_next();
        wait_and_compare(e);
        check("t5_issue_valid", replay_valid, 1);
        reset = 1'b0;
        tick();
        check("t5_valid", replay_valid, 0);
        check("t5_busy", busy, 0);
        check("t5_done", done, 0);
        check("t5_count", entry_count, 0);
        check("t5_loc", replay_location, 0);
        check("t5_act", replay_action, 0);
        check("t5_nloc", replay_n_location, 0);
        check("t5_rew", replay_reward, 0);
        reset = 1'b1;
        model_reset();
        for (int k = 0; k < 3; k++) begin
            tick();
            check("t5_no_done", done, 0);
        end
        cap(8'h12, 2'b01, 8'h13, 11'h005);
        run_session(0, 1'b0, 1'b0);

        // 6: three entries; first replay is the latest one when the feature is built in
        model_reset();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        cap(8'd1, 2'd1, 8'd2, 11'h011);
        cap(8'd2, 2'd2, 8'd3, 11'h022);
        cap(8'd3, 2'd3, 8'd4, 11'h033);
        check("t6_count", entry_count, 3);
        run_session(0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
